bcd2bin_shift: RTL and testbench

BCD2BIN_SHIFT -- requirements
Module: bcd2bin_shift

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_digit_uncorrect.sv | 17 +
 rtl/bcd2bin_shift.sv | 132 +++++++++++++
 tb/tb_bcd2bin_shift.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// Holds the FSM state enum, digit width and the reverse double-dabble correction constants.
package bcd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StDone
  } state_e;

  localparam int unsigned DigitW = 4;

  localparam logic [DigitW-1:0] CorrThresh = 4'd8;
  localparam logic [DigitW-1:0] CorrAmt    = 4'd3;
  localparam logic [DigitW-1:0] MaxDigit   = 4'd9;

  function automatic logic digit_invalid(input logic [DigitW-1:0] digit);
    return digit > MaxDigit;
  endfunction

endpackage

// File: rtl/bcd_digit_uncorrect.sv
// Reverse double-dabble correction cell: a digit of 8 or more has 3 subtracted.
// Undoes the add-3 adjustment made by the forward binary-to-BCD cell.
module bcd_digit_uncorrect
  import bcd_pkg::*;
(
  input  logic [DigitW-1:0] i_digit,
  output logic [DigitW-1:0] o_digit
);

  always_comb begin
    o_digit = i_digit;
    if (i_digit >= CorrThresh) begin
      o_digit = i_digit - CorrAmt;
    end
  end

endmodule

// File: rtl/bcd2bin_shift.sv
// Sequential packed-BCD to binary converter using one reverse double-dabble step per cycle.
// Operands containing a non-decimal digit are flagged and complete without conversion.
module bcd2bin_shift
  import bcd_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned BIN_W    = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DigitW*N_DIGITS-1:0] bcd_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BIN_W-1:0]           bin_out,
  output logic                       bcd_err
);

  localparam int unsigned BcdW = DigitW * N_DIGITS;
  localparam int unsigned CntW = $clog2(BIN_W + 1);

  state_e r_state;
  state_e w_state_next;

  logic [BcdW-1:0]  r_bcd;
  logic [BIN_W-1:0] r_bin;
  logic [CntW-1:0]  r_cnt;
  logic [BIN_W-1:0] r_bin_out;
  logic             r_err;

  logic             w_in_hs;
  logic             w_in_bad;
  logic             w_last_step;
  logic [BcdW-1:0]  w_bcd_shift;
  logic [BcdW-1:0]  w_bcd_step;
  logic [BIN_W-1:0] w_bin_shift;

  assign w_in_hs     = in_valid & in_ready;
  assign w_last_step = (r_cnt == CntW'(BIN_W - 1));

  // The BCD LSB falls into the binary MSB; the BCD register refills with zeros.
  assign w_bcd_shift = r_bcd >> 1;
  assign w_bin_shift = {r_bcd[0], r_bin[BIN_W-1:1]};

  always_comb begin
    w_in_bad = 1'b0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      w_in_bad = w_in_bad | digit_invalid(bcd_in[i*DigitW +: DigitW]);
    end
  end

  for (genvar g = 0; g < int'(N_DIGITS); g++) begin : g_uncorrect
    bcd_digit_uncorrect u_uncorrect (
      .i_digit (w_bcd_shift[g*DigitW +: DigitW]),
      .o_digit (w_bcd_step[g*DigitW +: DigitW])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_in_hs) begin
          w_state_next = w_in_bad ? StDone : StConv;
        end
      end
      StConv: begin
        if (w_last_step) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == StIdle);
    out_valid = (r_state == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcd     <= '0;
      r_bin     <= '0;
      r_cnt     <= '0;
      r_bin_out <= '0;
      r_err     <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_in_hs) begin
            r_bcd <= bcd_in;
            r_bin <= '0;
            r_cnt <= '0;
            r_err <= w_in_bad;
            if (w_in_bad) begin
              r_bin_out <= '0;
            end
          end
        end
        StConv: begin
          r_bcd <= w_bcd_step;
          r_bin <= w_bin_shift;
          r_cnt <= r_cnt + CntW'(1);
          if (w_last_step) begin
            r_bin_out <= w_bin_shift;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bin_out = r_bin_out;
  assign bcd_err = r_err;

endmodule

// File: tb/tb_bcd2bin_shift.sv
// Directed self-checking bench for bcd2bin_shift with hand-computed expected results.
module tb_bcd2bin_shift;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] bcd_in;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] bin_out;
  logic        bcd_err;

  int n_checks = 0;
  int n_fail   = 0;

  bcd2bin_shift #(
    .N_DIGITS (4),
    .BIN_W    (14)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .bcd_err   (bcd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic handshake(input logic [15:0] v);
    in_valid = 1'b1;
    bcd_in   = v;
    tick();
    in_valid = 1'b0;
  endtask

  // Counts edges after the handshake edge until out_valid; optionally drives junk inputs meanwhile.
  task automatic wait_valid(input bit noise, output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (noise) begin
        in_valid = lat[0];
        bcd_in   = 16'h9999 - 16'(lat);
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ov_low"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic convert(input string tag, input logic [15:0] v, input logic [13:0] exp_bin,
                         input bit noise);
    int lat;
    handshake(v);
    wait_valid(noise, lat);
    check({tag, "_latency"}, 32'(lat), 32'd14);
    check({tag, "_bin"}, 32'(bin_out), 32'(exp_bin));
    check({tag, "_err"}, 32'(bcd_err), 32'd0);
    release_out(tag);
  endtask

  initial begin
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    bcd_in    = '0;
    out_ready = 1'b0;
    #3;
    // Reset values must be present before any clock edge.
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_bin", 32'(bin_out), 32'd0);
    check("rst_err", 32'(bcd_err), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    convert("c1234", 16'h1234, 14'h04D2, 1'b0);
    convert("c9999", 16'h9999, 14'h270F, 1'b0);
    convert("c0000", 16'h0000, 14'h0000, 1'b0);

    // Invalid digit: DONE is entered directly on the handshake edge.
    handshake(16'h12A4);
    check("bad_ov", 32'(out_valid), 32'd1);
    check("bad_err", 32'(bcd_err), 32'd1);
    check("bad_bin", 32'(bin_out), 32'd0);
    release_out("bad");

    // Back-pressure in DONE: 567 = 0x237.
    handshake(16'h0567);
    wait_valid(1'b0, lat);
    check("stall_latency", 32'(lat), 32'd14);
    for (int i = 0; i < 5; i++) begin
      check("stall_ov", 32'(out_valid), 32'd1);
      check("stall_bin", 32'(bin_out), 32'h237);
      check("stall_err", 32'(bcd_err), 32'd0);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    release_out("stall");

    // Reset mid-conversion after 7 steps, asserted between edges.
    handshake(16'h1234);
    repeat (7) tick();
    #2;
    rst = 1'b1;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_bin", 32'(bin_out), 32'd0);
    check("abort_err", 32'(bcd_err), 32'd0);
    tick();
    rst = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) lat++;
      tick();
    end
    check("abort_no_ov", 32'(lat), 32'd0);
    convert("c0042", 16'h0042, 14'd42, 1'b0);

    // Junk in_valid traffic during CONV must not disturb 815 = 0x32F.
    convert("noise", 16'h0815, 14'h032F, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
